// File: rtl/uart_tx_hold_pkg.sv
// Shared definitions for the UART transmitter with one-entry holding register:
// one-hot FSM codes, default frame geometry and a width helper.
package uart_tx_hold_pkg;

  localparam int N_BITS_DATA_DEF  = 8;
  localparam int N_TICKS_BIT_DEF  = 16;
  localparam int N_TICKS_STOP_DEF = 16;
  localparam int N_BITS_STATE     = 4;

  typedef enum logic [N_BITS_STATE-1:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } tx_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Frame serializer: start bit, LSB-first data bits, stop bit, paced by the
// 16x baud tick. A start request is accepted in IDLE or on the final stop tick.
module uart_tx_shifter
  import uart_tx_hold_pkg::*;
#(
  parameter int N_BITS_DATA  = N_BITS_DATA_DEF,
  parameter int N_TICKS_BIT  = N_TICKS_BIT_DEF,
  parameter int N_TICKS_STOP = N_TICKS_STOP_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_tick,
  input  logic                   start,
  input  logic [N_BITS_DATA-1:0] data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done_tick
);

  localparam int CNT_W = bits_for(max_int(N_TICKS_BIT, N_TICKS_STOP));
  localparam int IDX_W = bits_for(N_BITS_DATA);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N_TICKS_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(N_TICKS_STOP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BITS_DATA - 1);

  tx_state_e              state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [N_BITS_DATA-1:0] shift_reg;
  logic [N_BITS_DATA-1:0] shift_dn;
  logic                   tx_reg;

  // Shift register contents after the current bit has been sent.
  for (genvar gi = 0; gi < N_BITS_DATA; gi++) begin : g_shift
    if (gi == N_BITS_DATA - 1) begin : g_msb
      assign shift_dn[gi] = 1'b0;
    end else begin : g_mid
      assign shift_dn[gi] = shift_reg[gi+1];
    end
  end

  assign done_tick = (state_reg == ST_STOP) && s_tick && (cnt_reg == STOP_LAST);
  assign busy      = (state_reg != ST_IDLE);
  assign tx        = tx_reg;

  // tx_reg is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= data;
            cnt_reg   <= '0;
            state_reg <= ST_START;
            tx_reg    <= 1'b0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (cnt_reg == BIT_LAST) begin
              cnt_reg   <= '0;
              idx_reg   <= '0;
              state_reg <= ST_DATA;
              tx_reg    <= shift_reg[0];
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (cnt_reg == BIT_LAST) begin
              cnt_reg   <= '0;
              shift_reg <= shift_dn;
              if (idx_reg == IDX_LAST) begin
                state_reg <= ST_STOP;
                tx_reg    <= 1'b1;
              end else begin
                idx_reg <= idx_reg + 1'b1;
                tx_reg  <= shift_dn[0];
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (cnt_reg == STOP_LAST) begin
              cnt_reg <= '0;
              if (start) begin
                shift_reg <= data;
                state_reg <= ST_START;
                tx_reg    <= 1'b0;
              end else begin
                state_reg <= ST_IDLE;
                tx_reg    <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          idx_reg   <= '0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_hold.sv
// UART transmitter fed by the ALU done tick, with a one-entry holding register
// so a second byte can be queued while a frame is on the line.
module uart_tx_hold
  import uart_tx_hold_pkg::*;
#(
  parameter int N_BITS_DATA  = N_BITS_DATA_DEF,
  parameter int N_TICKS_BIT  = N_TICKS_BIT_DEF,
  parameter int N_TICKS_STOP = N_TICKS_STOP_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_tick_i,
  input  logic                   tx_start_i,
  input  logic [N_BITS_DATA-1:0] data_i,
  output logic                   tx_o,
  output logic                   tx_done_tick_o,
  output logic                   busy_o,
  output logic                   hold_full_o,
  output logic                   overrun_o
);

  logic [N_BITS_DATA-1:0] hold_reg;
  logic                   hold_valid_reg;
  logic                   sh_start;
  logic [N_BITS_DATA-1:0] sh_data;
  logic                   sh_busy;
  logic                   sh_done;

  // The shifter takes a new byte when idle, or on its final stop tick if
  // anything is waiting (held byte first, else the coincident request).
  assign sh_start = (!sh_busy && tx_start_i) ||
                    (sh_done && (hold_valid_reg || tx_start_i));
  assign sh_data  = (sh_done && hold_valid_reg) ? hold_reg : data_i;

  // A request landing on the final stop tick always finds room, because the
  // held byte moves out in the same cycle.
  assign overrun_o      = sh_busy && tx_start_i && hold_valid_reg && !sh_done;
  assign tx_done_tick_o = sh_done;
  assign busy_o         = sh_busy;
  assign hold_full_o    = hold_valid_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else if (sh_done) begin
      if (hold_valid_reg) begin
        if (tx_start_i) begin
          hold_reg <= data_i;
        end else begin
          hold_valid_reg <= 1'b0;
        end
      end
    end else if (sh_busy && tx_start_i && !hold_valid_reg) begin
      hold_reg       <= data_i;
      hold_valid_reg <= 1'b1;
    end
  end

  uart_tx_shifter #(
    .N_BITS_DATA (N_BITS_DATA),
    .N_TICKS_BIT (N_TICKS_BIT),
    .N_TICKS_STOP(N_TICKS_STOP)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .s_tick   (s_tick_i),
    .start    (sh_start),
    .data     (sh_data),
    .tx       (tx_o),
    .busy     (sh_busy),
    .done_tick(sh_done)
  );

endmodule

// File: tb/tb_uart_tx_hold.sv
// Bench for uart_tx_hold: directed requests push expected bytes into a queue;
// a serial-line monitor decodes frames on baud ticks and pops to compare.
module tb_uart_tx_hold;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick_i = 1'b0;
  logic       tx_start_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       tx_o;
  logic       tx_done_tick_o;
  logic       busy_o;
  logic       hold_full_o;
  logic       overrun_o;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         tick_div = 1;
  bit         mon_active = 1'b0;
  int         mon_p = 0;
  int         frames_seen = 0;
  int         gapless = 0;

  uart_tx_hold dut (
    .clock         (clock),
    .reset         (reset),
    .s_tick_i      (s_tick_i),
    .tx_start_i    (tx_start_i),
    .data_i        (data_i),
    .tx_o          (tx_o),
    .tx_done_tick_o(tx_done_tick_o),
    .busy_o        (busy_o),
    .hold_full_o   (hold_full_o),
    .overrun_o     (overrun_o)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Baud tick every tick_div cycles, driven just after the rising edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clock);
      #1;
      ph++;
      s_tick_i = ((ph % tick_div) == 0);
    end
  end

  // Line monitor: one sample per baud tick, 16 per bit; mid-bit sampling.
  initial begin : monitor
    int         bi;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    bit         exp_done;
    bit         just_ended;
    mon_byte   = 8'h00;
    just_ended = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mon_active = 1'b0;
        just_ended = 1'b0;
        exp_q.delete();
        continue;
      end
      exp_done = 1'b0;
      if (s_tick_i) begin
        if (mon_active) begin
          mon_p++;
        end else if (tx_o == 1'b0) begin
          mon_active = 1'b1;
          mon_p = 0;
          if (just_ended) gapless++;
        end
        just_ended = 1'b0;
        if (mon_active) begin
          check("busy_in_frame", busy_o, 1);
          if ((mon_p % 16) == 8) begin
            bi = mon_p / 16;
            if (bi == 0) begin
              check("start_bit", tx_o, 0);
            end else if (bi <= 8) begin
              mon_byte[bi-1] = tx_o;
            end else begin
              check("stop_bit", tx_o, 1);
              frames_seen++;
              $display("rx frame %02h", mon_byte);
              if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_unexpected: got %02h, required no frame", mon_byte);
              end else begin
                exp_b = exp_q.pop_front();
                check("frame_byte", mon_byte, exp_b);
              end
            end
          end
          if (mon_p == 159) begin
            exp_done   = 1'b1;
            mon_active = 1'b0;
            just_ended = 1'b1;
          end
        end
      end
      check("done_tick", tx_done_tick_o, exp_done);
      if (!tx_start_i) check("overrun_no_req", overrun_o, 0);
    end
  end

  // Called just after a rising edge; request is sampled at the next edge.
  task automatic send(input logic [7:0] d, input bit exp_ovr);
    $display("send %02h expect_overrun=%0d", d, exp_ovr);
    tx_start_i = 1'b1;
    data_i     = d;
    if (!exp_ovr) exp_q.push_back(d);
    @(negedge clock);
    check("overrun", overrun_o, exp_ovr);
    @(posedge clock);
    #1;
    tx_start_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy_o) && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= bound) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got %0d frames pending after %0d cycles, required 0", exp_q.size(), bound);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before 1ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic       exp_bit;
    int         f0;
    int         g0;

    // Reset state
    wait_cycles(3);
    reset = 1'b1;
    @(negedge clock);
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_hold", hold_full_o, 0);
    check("rst_done", tx_done_tick_o, 0);
    check("rst_overrun", overrun_o, 0);

    // Idle with ticks every cycle
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      check("idle_tx", tx_o, 1);
      check("idle_busy", busy_o, 0);
    end
    wait_cycles(1);

    // 0xA5 exact waveform, one tick per clock
    pat = 8'hA5;
    send(pat, 1'b0);
    for (int k = 0; k < 160; k++) begin
      @(negedge clock);
      if (k < 16) exp_bit = 1'b0;
      else if (k < 144) exp_bit = pat[(k-16)/16];
      else exp_bit = 1'b1;
      check("a5_wave", tx_o, exp_bit);
    end
    wait_idle(400);
    wait_cycles(5);

    // Slow baud: tick every 4th clock
    tick_div = 4;
    wait_cycles(4);
    send(8'h3C, 1'b0);
    wait_idle(2000);
    tick_div = 1;
    wait_cycles(5);

    // Hold then overrun
    f0 = frames_seen;
    g0 = gapless;
    send(8'h11, 1'b0);
    wait_cycles(49);
    send(8'h22, 1'b0);
    @(negedge clock);
    check("hold_after_22", hold_full_o, 1);
    wait_cycles(8);
    send(8'h33, 1'b1);
    @(negedge clock);
    check("hold_after_33", hold_full_o, 1);
    wait_idle(800);
    check("frames_11_22", frames_seen - f0, 2);
    check("gapless_11_22", gapless - g0, 1);
    check("hold_empty_end", hold_full_o, 0);
    wait_cycles(5);

    // Request coincident with the final stop tick while hold is full
    f0 = frames_seen;
    g0 = gapless;
    send(8'h44, 1'b0);
    wait_cycles(20);
    send(8'h55, 1'b0);
    wait_cycles(138);
    check("hold_before_coinc", hold_full_o, 1);
    send(8'h66, 1'b0);
    @(negedge clock);
    check("hold_after_coinc", hold_full_o, 1);
    check("busy_after_coinc", busy_o, 1);
    check("tx_start_after_coinc", tx_o, 0);
    wait_idle(1200);
    check("frames_coinc", frames_seen - f0, 3);
    check("gapless_coinc", gapless - g0, 2);
    wait_cycles(5);

    // Reset in the middle of a frame with a byte held
    send(8'hFF, 1'b0);
    wait_cycles(60);
    send(8'h77, 1'b0);
    @(negedge clock);
    check("hold_before_rst", hold_full_o, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx", tx_o, 1);
    check("midrst_busy", busy_o, 0);
    check("midrst_hold", hold_full_o, 0);
    wait_cycles(3);
    f0 = frames_seen;
    send(8'h01, 1'b0);
    wait_idle(400);
    check("frames_after_rst", frames_seen - f0, 1);

    wait_cycles(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
